pipeline_flow_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. It consumes the EX-stage control-hazard flag,
//  the ID load-use flag and the IMEM/DMEM ready handshakes, and drives per-stage hold/flush/bubble controls.
//  It also owns a pending-redirect register, so a taken branch or jump is never lost while IMEM is busy.
//  It keeps saturating stall/flush performance counters and a DMEM-timeout flag.

---
 rtl/pipeline_flow_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: stall/flush sequencer with pending-redirect register, perf counters and DMEM timeout
module pipeline_flow_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             ctrl_hazard,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             load_use,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             redirect_vld,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIR_PEND} state_t;
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic             stall, pend, accept;
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_flush   = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    accept       = 1'b0;
    state_d      = state_q;
    pend_pc_d    = pend_pc_q;
    stall        = dmem_req & ~dmem_ready;
    pend         = state_q == REDIR_PEND;
    if (cpu_rst) begin
      state_d = RUN;
    end else if (stall) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = pend ? REDIR_PEND : MEM_WAIT;
    end else if (pend || ctrl_hazard) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      redirect_vld = 1'b1;
      redirect_pc  = pend ? pend_pc_q : ex_target;
      accept       = imem_ready;
      state_d      = imem_ready ? RUN : REDIR_PEND;
      pend_pc_d    = pend || imem_ready ? pend_pc_q : ex_target;
    end else begin
      // MEM_WAIT without an outstanding stall behaves exactly like RUN
      state_d    = RUN;
      pc_hold    = load_use | ~imem_ready;
      ifid_hold  = load_use;
      idex_flush = load_use;
      ifid_flush = ~load_use & ~imem_ready;
    end
    wait_d      = stall ? (wait_q == WW'(MEM_TIMEOUT) ? wait_q : wait_q + 1'b1) : '0;
    timeout_d   = timeout_q | (wait_d == WW'(MEM_TIMEOUT));
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_hold && stall_cnt_q != '1);
    flush_cnt_d = flush_cnt_q + CNT_W'(accept && flush_cnt_q != '1);
  end
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= RUN;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
    end
  end
  assign stall_cnt   = cpu_rst ? '0 : stall_cnt_q;
  assign flush_cnt   = cpu_rst ? '0 : flush_cnt_q;
  assign mem_timeout = ~cpu_rst & timeout_q;
endmodule
